// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush, hold and sticky halt.
// Optional performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        id_opcode,
  input  logic [1:0]        id_branch,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_memread,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_halt,
  input  logic              id_pcs,
  input  logic              id_loadbyte,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc2,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        ex_branch,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_memread,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic              ex_halt,
  output logic              ex_pcs,
  output logic              ex_loadbyte,
  output logic [3:0]        ex_opcode,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc2,
  output logic              halt_latched
`ifdef ID_EX_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        branch;
    logic              memtoreg;
    logic              memwrite;
    logic              memread;
    logic              alusrc;
    logic              regwrite;
    logic              halt;
    logic              pcs;
    logic              loadbyte;
    logic [3:0]        opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc2;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic halt_q, halt_d;
  logic use_rs, use_rt, use_rd;
  logic hazard;

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    use_rd = 1'b0;
    case (id_opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0111, 4'b1001:                   begin use_rs = 1'b1; use_rt = 1'b1; end
      4'b0100, 4'b0101, 4'b0110,
      4'b1000, 4'b1101:                   use_rs = 1'b1;
      4'b1010, 4'b1011:                   use_rd = 1'b1;
      default:                            ;
    endcase
  end

  // Hazard looks only at EX; after one bubble EX no longer holds the load.
  always_comb begin
    hazard = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
             ((use_rs && (id_rs == ex_q.rd)) ||
              (use_rt && (id_rt == ex_q.rd)) ||
              (use_rd && (id_rd == ex_q.rd)));
    stall  = hazard && !flush && !halt_q;
  end

  always_comb begin
    ex_d = ex_q;
    if (!hold) begin
      if (flush || halt_q || stall) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = 1'b1;
        ex_d.branch   = id_branch;
        ex_d.memtoreg = id_memtoreg;
        ex_d.memwrite = id_memwrite;
        ex_d.memread  = id_memread;
        ex_d.alusrc   = id_alusrc;
        ex_d.regwrite = id_regwrite;
        ex_d.halt     = id_halt;
        ex_d.pcs      = id_pcs;
        ex_d.loadbyte = id_loadbyte;
        ex_d.opcode   = id_opcode;
        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
        ex_d.rd       = id_rd;
        ex_d.rdata1   = id_rdata1;
        ex_d.rdata2   = id_rdata2;
        ex_d.imm      = id_imm;
        ex_d.pc2      = id_pc2;
      end
    end
    halt_d = halt_q || (ex_d.valid && ex_d.halt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      halt_q <= halt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_branch    = ex_q.branch;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_memread   = ex_q.memread;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_halt      = ex_q.halt;
  assign ex_pcs       = ex_q.pcs;
  assign ex_loadbyte  = ex_q.loadbyte;
  assign ex_opcode    = ex_q.opcode;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_rd        = ex_q.rd;
  assign ex_rdata1    = ex_q.rdata1;
  assign ex_rdata2    = ex_q.rdata2;
  assign ex_imm       = ex_q.imm;
  assign ex_pc2       = ex_q.pc2;
  assign halt_latched = halt_q;

`ifdef ID_EX_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush && !hold && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; perf counter checks run when ID_EX_PERF_EN is defined.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_opcode;
  logic [1:0]  id_branch;
  logic        id_memtoreg, id_memwrite, id_memread, id_alusrc;
  logic        id_regwrite, id_halt, id_pcs, id_loadbyte;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rdata1, id_rdata2, id_imm, id_pc2;
  logic        flush, hold;
  logic        stall, ex_valid;
  logic [1:0]  ex_branch;
  logic        ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc;
  logic        ex_regwrite, ex_halt, ex_pcs, ex_loadbyte;
  logic [3:0]  ex_opcode, ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc2;
  logic        halt_latched;
`ifdef ID_EX_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_opcode(id_opcode), .id_branch(id_branch),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_memread(id_memread),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_halt(id_halt),
    .id_pcs(id_pcs), .id_loadbyte(id_loadbyte),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc2(id_pc2),
    .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_memread(ex_memread), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_halt(ex_halt), .ex_pcs(ex_pcs), .ex_loadbyte(ex_loadbyte),
    .ex_opcode(ex_opcode), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc2(ex_pc2),
    .halt_latched(halt_latched)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents a decode instruction with control bits a simple decoder would produce.
  task automatic set_id(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd);
    id_opcode   = op;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_branch   = (op == 4'b1100) ? 2'b11 : 2'b00;
    id_memread  = (op == 4'b1000);
    id_memtoreg = (op == 4'b1000);
    id_memwrite = (op == 4'b1001);
    id_halt     = (op == 4'b1111);
    id_alusrc   = (op == 4'b1000) || (op == 4'b1001);
    id_regwrite = !((op == 4'b1001) || (op == 4'b1100) || (op == 4'b1111));
    id_pcs      = 1'b0;
    id_loadbyte = 1'b0;
    id_rdata1   = 16'h1000 + 16'(rs);
    id_rdata2   = 16'h2000 + 16'(rt);
    id_imm      = 16'h3000 + 16'(rd);
    id_pc2      = 16'h4000 + 16'(op);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    set_id(4'b1100, 4'd0, 4'd0, 4'd0);
    #2;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_halt", 32'(halt_latched), 32'd0);
    check("rst_regwrite", 32'(ex_regwrite), 32'd0);
    check("rst_pc2", 32'(ex_pc2), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD r3 = r1 + r2
    set_id(4'b0000, 4'd1, 4'd2, 4'd3);
    check("add_stall", 32'(stall), 32'd0);
    step();
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_regwrite", 32'(ex_regwrite), 32'd1);
    check("add_rd", 32'(ex_rd), 32'd3);
    check("add_rdata1", 32'(ex_rdata1), 32'h1001);
    check("add_rdata2", 32'(ex_rdata2), 32'h2002);
    check("add_pc2", 32'(ex_pc2), 32'h4000);

    // LW r4 then SUB using r4
    set_id(4'b1000, 4'd1, 4'd0, 4'd4);
    step();
    check("lw_memread", 32'(ex_memread), 32'd1);
    set_id(4'b0001, 4'd4, 4'd6, 4'd7);
    check("lu_stall", 32'(stall), 32'd1);
    step();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_memread", 32'(ex_memread), 32'd0);
    check("lu_stall_clear", 32'(stall), 32'd0);
    step();
    check("lu_sub_valid", 32'(ex_valid), 32'd1);
    check("lu_sub_rs", 32'(ex_rs), 32'd4);
    check("lu_sub_opcode", 32'(ex_opcode), 32'd1);

    // rd-as-source opcode, and no-source opcode
    set_id(4'b1000, 4'd1, 4'd0, 4'd9);
    step();
    set_id(4'b1100, 4'd9, 4'd9, 4'd0);
    check("nosrc_stall", 32'(stall), 32'd0);
    set_id(4'b1010, 4'd0, 4'd0, 4'd9);
    check("rdsrc_stall", 32'(stall), 32'd1);
    step();
    check("rdsrc_bubble", 32'(ex_valid), 32'd0);
    step();
    check("rdsrc_loaded", 32'(ex_opcode), 32'hA);

    // LW r0 never stalls
    set_id(4'b1000, 4'd1, 4'd0, 4'd0);
    step();
    set_id(4'b0000, 4'd0, 4'd2, 4'd3);
    check("r0_stall", 32'(stall), 32'd0);
    step();
    check("r0_valid", 32'(ex_valid), 32'd1);

    // flush overrides a load-use stall
    set_id(4'b1000, 4'd1, 4'd0, 4'd5);
    step();
    set_id(4'b1001, 4'd1, 4'd5, 4'd0);
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    step();
    flush = 1'b0;
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_memwrite", 32'(ex_memwrite), 32'd0);

    // back-to-back loads: each dependent consumer stalls once
    set_id(4'b1000, 4'd1, 4'd0, 4'd6);
    step();
    set_id(4'b1000, 4'd6, 4'd0, 4'd6);
    check("b2b_stall1", 32'(stall), 32'd1);
    step();
    check("b2b_stall1_clear", 32'(stall), 32'd0);
    step();
    check("b2b_lw2_valid", 32'(ex_memread), 32'd1);
    set_id(4'b0000, 4'd6, 4'd1, 4'd2);
    check("b2b_stall2", 32'(stall), 32'd1);
    step();
    check("b2b_stall2_clear", 32'(stall), 32'd0);
    step();
    check("b2b_add_valid", 32'(ex_valid), 32'd1);

    // hold with ADD in EX
    set_id(4'b0000, 4'd1, 4'd2, 4'd3);
    step();
    set_id(4'b0001, 4'd5, 4'd6, 4'd8);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_rd", 32'(ex_rd), 32'd3);
      check("hold_opcode", 32'(ex_opcode), 32'd0);
    end
    hold = 1'b0;
    step();
    check("release_rd", 32'(ex_rd), 32'd8);

    // stall is still reported under hold, and no bubble is loaded
    set_id(4'b1000, 4'd1, 4'd0, 4'd10);
    step();
    set_id(4'b0000, 4'd10, 4'd1, 4'd2);
    hold = 1'b1;
    #1;
    check("hold_stall", 32'(stall), 32'd1);
    step();
    check("hold_stall_keep", 32'(ex_memread), 32'd1);
    check("hold_stall_again", 32'(stall), 32'd1);
    hold = 1'b0;
    step();
    check("hold_stall_bubble", 32'(ex_valid), 32'd0);
    step();
    check("hold_stall_add", 32'(ex_rs), 32'd10);

    // HLT is sticky
    set_id(4'b1111, 4'd0, 4'd0, 4'd0);
    step();
    check("hlt_latched", 32'(halt_latched), 32'd1);
    check("hlt_ex_halt", 32'(ex_halt), 32'd1);
    set_id(4'b0000, 4'd1, 4'd2, 4'd3);
    step();
    check("hlt_bubble1", 32'(ex_valid), 32'd0);
    step();
    check("hlt_bubble2", 32'(ex_regwrite), 32'd0);
    check("hlt_still", 32'(halt_latched), 32'd1);

`ifdef ID_EX_PERF_EN
    check("perf_stall", 32'(perf_stall_cnt), 32'd5);
    check("perf_flush", 32'(perf_flush_cnt), 32'd1);
`endif

    // reset in the middle of a stall
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_id(4'b1000, 4'd1, 4'd0, 4'd4);
    step();
    set_id(4'b0001, 4'd4, 4'd6, 4'd7);
    check("mid_pre_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_stall_drop", 32'(stall), 32'd0);
    check("mid_valid", 32'(ex_valid), 32'd0);
    check("mid_halt", 32'(halt_latched), 32'd0);
`ifdef ID_EX_PERF_EN
    check("mid_perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 16-bit pipelined core, directly downstream of the instruction-decode control logic.
- Captures decoded control signals, operands and register specifiers each cycle.
- Detects load-use hazards against the instruction currently in EX, stalling decode and injecting bubbles.
- Handles branch flush, external hold, and sticky halt.

Parameters:
DATA_W, 16, operand/immediate/PC width
REG_W, 4, register specifier width (16 registers, R0 reads zero)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
id_opcode  input  4  instruction[15:12] of the decode-stage instruction
id_branch  input  2  decoder Branch[1:0] (11=B, 10=BR)
id_memtoreg, id_memwrite, id_memread, id_alusrc, id_regwrite, id_halt, id_pcs, id_loadbyte  input  1 each  decoder control bits
id_rs, id_rt, id_rd  input  REG_W  register specifiers
id_rdata1, id_rdata2, id_imm, id_pc2  input  DATA_W  RF read data, extended immediate, PC+2
flush  input  1  kill the decode instruction (taken branch), load bubble
hold  input  1  freeze this stage entirely (memory wait)
stall  output  1  combinational; freeze PC and IF/ID this cycle
ex_valid  output  1  EX holds a real instruction
ex_branch  output  2  registered control
ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc, ex_regwrite, ex_halt, ex_pcs, ex_loadbyte  output  1 each  registered control
ex_opcode  output  4
ex_rs, ex_rt, ex_rd  output  REG_W
ex_rdata1, ex_rdata2, ex_imm, ex_pc2  output  DATA_W
halt_latched  output  1  sticky; a HLT has entered EX

Behaviour:
- Reset (async, rst_n=0): every registered output = 0, so EX holds a bubble. halt_latched = 0.
- Bubble: ex_valid = 0 and all control outputs = 0. Data and specifier fields are don't-care but driven 0.
- Source usage decoded from id_opcode:
  - rs+rt: 0000-0011, 0111.
  - rs+rt (base + store data): 1001.
  - rs only: 0100-0110, 1000, 1101.
  - rd used as source: 1010, 1011.
  - None: 1100, 1110, 1111.
- Load-use hazard: ex_valid & ex_memread & ex_rd != 0 & ex_rd equals any used source of the decode instruction.
- stall = hazard & ~flush & ~halt_latched. Combinational, zero latency.
- Per-edge priority (highest first):
  - hold: all registers keep value; stall is still reported.
  - flush: load bubble.
  - halt_latched: load bubble.
  - stall: load bubble. The decode instruction is re-presented next cycle and its hazard clears because EX now holds the bubble, so a load-use costs exactly 1 cycle.
  - Otherwise: load all id_* fields with ex_valid = 1.
- halt_latched sets on the edge where ex_halt=1 and ex_valid=1 are registered. It clears only on reset. After it sets, EX receives bubbles forever.
- No arithmetic inside the block. Widths pass through unmodified.
- Back-to-back loads to the same register stall once per dependent consumer, never twice.
- Reset mid-stall: stall drops in the same cycle as rst_n falls, because EX is forced to a bubble asynchronously.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined: adds outputs perf_stall_cnt[15:0] and perf_flush_cnt[15:0].
  - perf_stall_cnt counts edges where stall=1 & ~hold.
  - perf_flush_cnt counts edges where flush=1 & ~hold.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter logic exists.

Test Plan:
- Reset, then decode ADD (0000, rs=1, rt=2, rd=3) -> next edge: ex_valid=1, ex_regwrite=1, ex_rd=3, stall=0.
- LW (1000, rd=4) followed by SUB rs=4 -> stall=1 for exactly one cycle, one bubble enters EX, then SUB loads with ex_rs=4.
- LW rd=0 followed by ADD rs=0 -> stall=0, no bubble.
- LW rd=5, then SW (1001) rt=5, with flush=1 on the stall cycle -> stall=0, EX gets a bubble, ex_memwrite=0.
- hold=1 for 3 cycles with ADD valid in EX -> ex_* unchanged. Release -> next instruction loads.
- HLT (1111) enters EX -> halt_latched=1. Subsequent ADDs are never valid in EX. With ID_EX_PERF_EN, 2 stalls yield perf_stall_cnt=2.
